// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl_pkg
// Description : Shared field widths and controller state encoding for dcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package dcache_ctrl_pkg;

    localparam int c_WORD_BITS      = 16;
    localparam int c_OFFSET_BITS    = 2;
    localparam int c_WORDS_PER_LINE = 2 ** c_OFFSET_BITS;
    localparam int c_LINE_BITS      = c_WORD_BITS * c_WORDS_PER_LINE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRBACK = 2'd1,
        ST_ALLOC  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : Tag/valid/dirty/data storage, combinational read, synchronous fill and word write.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int TAG_BITS   = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [INDEX_BITS-1:0]    idx,
    output logic                     rd_valid,
    output logic                     rd_dirty,
    output logic [TAG_BITS-1:0]      rd_tag,
    output logic [c_LINE_BITS-1:0]   rd_line,
    input  logic                     fill_en,
    input  logic [TAG_BITS-1:0]      fill_tag,
    input  logic [c_LINE_BITS-1:0]   fill_line,
    input  logic                     wr_en,
    input  logic [c_OFFSET_BITS-1:0] wr_off,
    input  logic [c_WORD_BITS-1:0]   wr_data
);

    localparam int c_LINES = 2 ** INDEX_BITS;

    logic [c_LINES-1:0]     r_valid;
    logic [c_LINES-1:0]     r_dirty;
    logic [TAG_BITS-1:0]    r_tag  [c_LINES];
    logic [c_LINE_BITS-1:0] r_data [c_LINES];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (fill_en) begin
            r_valid[idx] <= 1'b1;
            r_dirty[idx] <= 1'b0;
        end else if (wr_en) begin
            r_dirty[idx] <= 1'b1;
        end
    end

    // Payload storage is deliberately left out of reset; valid bits guard it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            r_tag[idx]  <= fill_tag;
            r_data[idx] <= fill_line;
        end else if (wr_en) begin
            r_data[idx][int'(wr_off)*c_WORD_BITS +: c_WORD_BITS] <= wr_data;
        end
    end

    assign rd_valid = r_valid[idx];
    assign rd_dirty = r_dirty[idx];
    assign rd_tag   = r_tag[idx];
    assign rd_line  = r_data[idx];

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dcache_ctrl
// Description : Direct-mapped write-back data cache controller with writeback/refill FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
    import dcache_ctrl_pkg::*;
#(
    parameter int INDEX_BITS = 3,
    parameter int ADDR_BITS  = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ADDR_BITS-1:0]            cpu_addr,
    input  logic                            cpu_re,
    input  logic                            cpu_we,
    input  logic [c_WORD_BITS-1:0]          cpu_wdata,
    output logic [c_WORD_BITS-1:0]          cpu_rdata,
    output logic                            cpu_stall,
    output logic [ADDR_BITS-c_OFFSET_BITS-1:0] mem_addr,
    output logic                            mem_re,
    output logic                            mem_we,
    output logic [c_LINE_BITS-1:0]          mem_wdata,
    input  logic [c_LINE_BITS-1:0]          mem_rdata,
    input  logic                            mem_rdy
);

    localparam int c_TAG_BITS = ADDR_BITS - INDEX_BITS - c_OFFSET_BITS;

    logic [INDEX_BITS-1:0]    w_idx;
    logic [c_TAG_BITS-1:0]    w_tag;
    logic [c_OFFSET_BITS-1:0] w_off;
    logic                     w_req;
    logic                     w_hit;
    logic                     w_line_valid;
    logic                     w_line_dirty;
    logic [c_TAG_BITS-1:0]    w_line_tag;
    logic [c_LINE_BITS-1:0]   w_line;

    state_t r_state;
    state_t w_next;
    logic   r_mem_re;
    logic   r_mem_we;

    logic                                  w_stall;
    logic                                  w_fill;
    logic                                  w_wr;
    logic [c_WORD_BITS-1:0]                w_rdata;
    logic [ADDR_BITS-c_OFFSET_BITS-1:0]    w_maddr;
    logic [c_LINE_BITS-1:0]                w_mwdata;

    assign w_idx = cpu_addr[INDEX_BITS+c_OFFSET_BITS-1:c_OFFSET_BITS];
    assign w_tag = cpu_addr[ADDR_BITS-1 -: c_TAG_BITS];
    assign w_off = cpu_addr[c_OFFSET_BITS-1:0];
    assign w_req = cpu_re | cpu_we;
    assign w_hit = w_req & w_line_valid & (w_line_tag == w_tag);

    cache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (c_TAG_BITS)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .idx       (w_idx),
        .rd_valid  (w_line_valid),
        .rd_dirty  (w_line_dirty),
        .rd_tag    (w_line_tag),
        .rd_line   (w_line),
        .fill_en   (w_fill & rst_n),
        .fill_tag  (w_tag),
        .fill_line (mem_rdata),
        .wr_en     (w_wr & rst_n),
        .wr_off    (w_off),
        .wr_data   (cpu_wdata)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_mem_re <= 1'b0;
            r_mem_we <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_mem_re <= (w_next == ST_ALLOC);
            r_mem_we <= (w_next == ST_WRBACK);
        end
    end

    always_comb begin
        w_next   = r_state;
        w_stall  = 1'b0;
        w_fill   = 1'b0;
        w_wr     = 1'b0;
        w_rdata  = '0;
        w_maddr  = '0;
        w_mwdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_hit) begin
                    // A simultaneous read+write is a write; read data is suppressed.
                    w_wr = cpu_we;
                    if (cpu_re && !cpu_we) begin
                        w_rdata = w_line[int'(w_off)*c_WORD_BITS +: c_WORD_BITS];
                    end
                end else if (w_req) begin
                    w_stall = 1'b1;
                    w_next  = (w_line_valid && w_line_dirty) ? ST_WRBACK : ST_ALLOC;
                end
            end
            ST_WRBACK: begin
                w_stall  = 1'b1;
                w_maddr  = {w_line_tag, w_idx};
                w_mwdata = w_line;
                if (mem_rdy) begin
                    w_next = ST_ALLOC;
                end
            end
            ST_ALLOC: begin
                w_stall = 1'b1;
                w_maddr = {w_tag, w_idx};
                if (mem_rdy) begin
                    w_fill = 1'b1;
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    assign cpu_stall = rst_n & w_stall;
    assign cpu_rdata = rst_n ? w_rdata  : '0;
    assign mem_addr  = rst_n ? w_maddr  : '0;
    assign mem_wdata = rst_n ? w_mwdata : '0;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dcache_ctrl
// Description : Scoreboard bench for dcache_ctrl with a fixed-latency line memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

    localparam int c_MEM_LAT = 4;
    localparam int c_K_WB    = 0;
    localparam int c_K_FILL  = 1;
    localparam int c_K_STALL = 2;
    localparam int c_K_RD    = 3;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] cpu_addr  = '0;
    logic        cpu_re    = 1'b0;
    logic        cpu_we    = 1'b0;
    logic [15:0] cpu_wdata = '0;
    logic [15:0] cpu_rdata;
    logic        cpu_stall;
    logic [13:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata = '0;
    logic        mem_rdy   = 1'b0;

    always #5 clk = ~clk;

    dcache_ctrl #(.INDEX_BITS(3), .ADDR_BITS(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_addr  (cpu_addr),
        .cpu_re    (cpu_re),
        .cpu_we    (cpu_we),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rdy   (mem_rdy)
    );

    typedef struct {
        int          kind;
        logic [63:0] a;
        logic [63:0] b;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    function automatic string kname(input int k);
        case (k)
            c_K_WB:    return "writeback";
            c_K_FILL:  return "fill";
            c_K_STALL: return "stall_cycles";
            default:   return "rdata";
        endcase
    endfunction

    task automatic push(input int k, input logic [63:0] a, input logic [63:0] b);
        ev_t e;
        e.kind = k;
        e.a    = a;
        e.b    = b;
        exp_q.push_back(e);
    endtask

    task automatic exp_wb(input logic [13:0] la, input logic [63:0] line);
        push(c_K_WB, 64'(la), line);
    endtask
    task automatic exp_fill(input logic [13:0] la);
        push(c_K_FILL, 64'(la), 64'd0);
    endtask
    task automatic exp_stall(input int n);
        push(c_K_STALL, 64'(n), 64'd0);
    endtask
    task automatic exp_rd(input logic [15:0] v);
        push(c_K_RD, 64'(v), 64'd0);
    endtask

    task automatic observe(input int k, input logic [63:0] a, input logic [63:0] b);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected: got a=%h b=%h, required no event", kname(k), a, b);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.b !== b) begin
                errors++;
                $display("FAIL %s: got %s a=%h b=%h, required %s a=%h b=%h",
                         kname(e.kind), kname(k), a, b, kname(e.kind), e.a, e.b);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Line memory: word value defaults to its own word address until written back.
    logic [63:0] mem [logic [13:0]];
    int          mcnt  = 0;
    logic        stray = 1'b0;

    function automatic logic [63:0] mem_line(input logic [13:0] la);
        if (mem.exists(la)) return mem[la];
        return {la, 2'd3, la, 2'd2, la, 2'd1, la, 2'd0};
    endfunction

    always @(negedge clk) begin
        if (mem_re || mem_we) begin
            mcnt++;
            if (mcnt == c_MEM_LAT) begin
                mcnt    = 0;
                mem_rdy = 1'b1;
                if (mem_re) mem_rdata = mem_line(mem_addr);
                else        mem[mem_addr] = mem_wdata;
            end else begin
                mem_rdy = 1'b0;
            end
        end else begin
            mcnt      = 0;
            mem_rdy   = stray;
            mem_rdata = stray ? 64'hDEAD_DEAD_DEAD_DEAD : 64'd0;
        end
    end

    // Monitor: turns DUT activity into events and retires them against the queue.
    int   scnt    = 0;
    logic prev_re = 1'b0;
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            scnt    = 0;
            prev_re = 1'b0;
            prev_we = 1'b0;
        end else begin
            if (mem_re && mem_we) begin
                checks++;
                errors++;
                $display("FAIL mem_exclusive: got mem_re=1 mem_we=1, required at most one");
            end
            if (mem_we && !prev_we) observe(c_K_WB, 64'(mem_addr), mem_wdata);
            if (mem_re && !prev_re) observe(c_K_FILL, 64'(mem_addr), 64'd0);
            prev_re = mem_re;
            prev_we = mem_we;
            if (cpu_re || cpu_we) begin
                if (cpu_stall) begin
                    scnt++;
                end else begin
                    observe(c_K_STALL, 64'(scnt), 64'd0);
                    if (cpu_re && !cpu_we) observe(c_K_RD, 64'(cpu_rdata), 64'd0);
                    scnt = 0;
                end
            end else begin
                scnt = 0;
                chk("idle_stall", 64'(cpu_stall), 64'd0);
            end
        end
    end

    task automatic req(input logic re, input logic we, input logic [15:0] a, input logic [15:0] d);
        int n;
        n         = 0;
        cpu_re    = re;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (cpu_stall && n < 64);
        if (cpu_stall) begin
            checks++;
            errors++;
            $display("FAIL req_timeout: addr %h still stalled after %0d cycles, required completion", a, n);
        end
        @(posedge clk);
        #1;
        cpu_re = 1'b0;
        cpu_we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required self-termination");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("rst_cpu_stall", 64'(cpu_stall), 64'd0);
        chk("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        chk("rst_mem_re",    64'(mem_re),    64'd0);
        chk("rst_mem_we",    64'(mem_we),    64'd0);
        chk("rst_mem_addr",  64'(mem_addr),  64'd0);
        chk("rst_mem_wdata", mem_wdata,      64'd0);
        @(posedge clk);
        #1;

        // Cold read miss, then a hit on the same line.
        exp_fill(14'h0004); exp_stall(5); exp_rd(16'h0010);
        req(1'b1, 1'b0, 16'h0010, 16'h0000);
        exp_stall(0); exp_rd(16'h0011);
        req(1'b1, 1'b0, 16'h0011, 16'h0000);

        // Dirty the line, then evict it with a conflicting tag.
        exp_stall(0);
        req(1'b0, 1'b1, 16'h0012, 16'hBEEF);
        exp_wb(14'h0004, 64'h0013_BEEF_0011_0010); exp_fill(14'h0024); exp_stall(9); exp_rd(16'h0092);
        req(1'b1, 1'b0, 16'h0092, 16'h0000);

        // Write-allocate miss, eviction carries the store, and memory holds it afterwards.
        exp_fill(14'h0080); exp_stall(5);
        req(1'b0, 1'b1, 16'h0200, 16'h1234);
        exp_wb(14'h0080, 64'h0203_0202_0201_1234); exp_fill(14'h0000); exp_stall(9); exp_rd(16'h0000);
        req(1'b1, 1'b0, 16'h0000, 16'h0000);
        exp_fill(14'h0080); exp_stall(5); exp_rd(16'h1234);
        req(1'b1, 1'b0, 16'h0200, 16'h0000);

        // Reset in the middle of a refill, then a stray mem_rdy while idle.
        exp_fill(14'h000C);
        cpu_re   = 1'b1;
        cpu_addr = 16'h0030;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_miss_mem_re", 64'(mem_re), 64'd1);
        rst_n  = 1'b0;
        cpu_re = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_mem_re",    64'(mem_re),    64'd0);
        chk("post_rst_mem_we",    64'(mem_we),    64'd0);
        chk("post_rst_cpu_stall", 64'(cpu_stall), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        @(posedge clk); #1;
        chk("stray_mem_re", 64'(mem_re), 64'd0);
        chk("stray_mem_we", 64'(mem_we), 64'd0);
        exp_fill(14'h000C); exp_stall(5); exp_rd(16'h0030);
        req(1'b1, 1'b0, 16'h0030, 16'h0000);
        exp_fill(14'h0024); exp_stall(5); exp_rd(16'h0092);
        req(1'b1, 1'b0, 16'h0092, 16'h0000);

        // Fill every index, then back-to-back hits across all of them.
        for (int i = 0; i < 8; i++) begin
            exp_fill(14'(14'h0040 + i)); exp_stall(5); exp_rd(16'(16'h0100 + 4 * i));
            req(1'b1, 1'b0, 16'(16'h0100 + 4 * i), 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            exp_stall(0); exp_rd(16'(16'h0100 + 4 * i + (i % 4)));
            req(1'b1, 1'b0, 16'(16'h0100 + 4 * i + (i % 4)), 16'h0000);
        end

        // Read+write together acts as a write only.
        exp_stall(0);
        req(1'b1, 1'b1, 16'h0105, 16'hA5A5);
        exp_stall(0); exp_rd(16'hA5A5);
        req(1'b1, 1'b0, 16'h0105, 16'h0000);
        exp_wb(14'h0041, 64'h0107_0106_A5A5_0104); exp_fill(14'h0001); exp_stall(9); exp_rd(16'h0005);
        req(1'b1, 1'b0, 16'h0005, 16'h0000);
        exp_stall(0); exp_rd(16'h0108);
        req(1'b1, 1'b0, 16'h0108, 16'h0000);

        repeat (4) @(posedge clk);
        #1;
        chk("events_left", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
